// File: rtl/powerup_scheduler.sv
// Frame-paced round-robin scheduler for one shared power-up slot, with a
// global cooldown and a slowly recharging energy pool charged per grant.
module powerup_scheduler #(
    parameter int unsigned N_REQ           = 3,
    parameter int unsigned ACTIVE_FRAMES   = 300,
    parameter int unsigned COOLDOWN_FRAMES = 600,
    parameter int unsigned ENERGY_MAX      = 15,
    parameter int unsigned COST            = 5,
    parameter int unsigned RECHARGE_FRAMES = 60,
    parameter int unsigned ENERGY_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    abort,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    active,
    output logic [N_REQ-1:0]    pending,
    output logic [ENERGY_W-1:0] energy,
    output logic                available,
    output logic [1:0]          state_o
);

    localparam int unsigned TMAX = (ACTIVE_FRAMES > COOLDOWN_FRAMES) ? ACTIVE_FRAMES : COOLDOWN_FRAMES;
    localparam int unsigned TW   = $clog2(TMAX + 2);
    localparam int unsigned RW   = $clog2(RECHARGE_FRAMES + 1);
    localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     rcnt;
    logic [IW-1:0]     rr;

    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [N_REQ-1:0]  sel_vec;
    logic              do_grant;
    logic [N_REQ-1:0]  grant_vec;
    logic              recharge_step;
    logic              recharge_tick;
    logic              end_active;
    logic              energy_ok;

    // Round-robin pick: lowest pending index above rr wins, else lowest at or below rr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i] && (IW'(i) <= rr)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i] && (IW'(i) > rr)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign sel_vec       = N_REQ'(1) << sel_idx;
    assign energy_ok     = (energy >= ENERGY_W'(COST));
    assign do_grant      = (state == IDLE) && frame && sel_found && energy_ok;
    assign grant_vec     = do_grant ? sel_vec : '0;
    assign recharge_step = frame && (state != ACTIVE);
    assign recharge_tick = recharge_step && (rcnt == RW'(RECHARGE_FRAMES - 1));
    assign end_active    = ((abort & active) != '0) || (frame && (timer <= TW'(1)));

    assign available = (state == IDLE) && energy_ok;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            active  <= '0;
            pending <= '0;
            energy  <= ENERGY_W'(ENERGY_MAX);
            rcnt    <= '0;
            timer   <= '0;
            rr      <= IW'(N_REQ - 1);
        end else begin
            grant   <= '0;
            // Requests for the running index are dropped; a grant clears its own bit.
            pending <= (pending | (req & ~active)) & ~grant_vec;

            if (recharge_step) begin
                rcnt <= recharge_tick ? '0 : rcnt + RW'(1);
            end

            // Grant is checked against pre-recharge energy; both can land on one frame.
            if (do_grant) begin
                energy <= energy - ENERGY_W'(COST) + ENERGY_W'(recharge_tick);
            end else if (recharge_tick && (energy != ENERGY_W'(ENERGY_MAX))) begin
                energy <= energy + ENERGY_W'(1);
            end

            case (state)
                IDLE: begin
                    if (do_grant) begin
                        grant  <= grant_vec;
                        active <= grant_vec;
                        timer  <= TW'(ACTIVE_FRAMES);
                        rr     <= sel_idx;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (end_active) begin
                        active <= '0;
                        if (COOLDOWN_FRAMES == 0) begin
                            timer <= '0;
                            state <= IDLE;
                        end else begin
                            timer <= TW'(COOLDOWN_FRAMES);
                            state <= COOLDOWN;
                        end
                    end else if (frame) begin
                        timer <= timer - TW'(1);
                    end
                end
                COOLDOWN: begin
                    if (frame) begin
                        if (timer <= TW'(1)) begin
                            timer <= '0;
                            state <= IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                default: begin
                    active <= '0;
                    timer  <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Bench for powerup_scheduler: directed scenarios then random traffic,
// every clk compared against a frame-level behavioural model.
module tb_powerup_scheduler;

    localparam int N  = 3;
    localparam int AF = 3;
    localparam int CF = 2;
    localparam int EM = 15;
    localparam int CO = 5;
    localparam int RF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] abort = '0;
    logic [2:0] grant;
    logic [2:0] active;
    logic [2:0] pending;
    logic [3:0] energy;
    logic       available;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 active, 2 cooldown; frames_left counts remaining frames.
    int         m_phase;
    int         m_left;
    int         m_energy;
    int         m_rc;
    int         m_rr;
    logic [2:0] m_pend;
    logic [2:0] m_act;
    logic [2:0] m_grant;

    powerup_scheduler #(
        .N_REQ(N), .ACTIVE_FRAMES(AF), .COOLDOWN_FRAMES(CF), .ENERGY_MAX(EM),
        .COST(CO), .RECHARGE_FRAMES(RF), .ENERGY_W(4)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .req(req), .abort(abort),
        .grant(grant), .active(active), .pending(pending), .energy(energy),
        .available(available), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_left = 0; m_energy = EM; m_rc = 0; m_rr = N - 1;
        m_pend = '0; m_act = '0; m_grant = '0;
    endtask

    task automatic check_all();
        chk("grant",     32'(grant),     32'(m_grant));
        chk("active",    32'(active),    32'(m_act));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("energy",    32'(energy),    32'(m_energy));
        chk("state",     32'(state_o),   32'(m_phase));
        chk("available", 32'(available), 32'((m_phase == 0) && (m_energy >= CO)));
    endtask

    // One clk of stimulus; the model advances by the same rules, then outputs are compared.
    task automatic tick(input logic f, input logic [2:0] r, input logic [2:0] a);
        int         sel;
        int         idx;
        bit         charge;
        logic [2:0] latched;
        frame = f; req = r; abort = a;
        charge  = f && (m_phase != 1) && (m_rc + 1 == RF);
        if (f && m_phase != 1) m_rc = charge ? 0 : m_rc + 1;
        latched = m_pend | (r & ~m_act);
        m_grant = '0;
        if (m_phase == 0 && f && m_pend != '0 && m_energy >= CO) begin
            sel = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_rr + k) % N;
                if (sel < 0 && ((m_pend >> idx) & 3'b001) != '0) sel = idx;
            end
            m_grant  = 3'(1 << sel);
            m_act    = m_grant;
            m_left   = AF;
            m_rr     = sel;
            m_phase  = 1;
            m_energy = m_energy - CO + (charge ? 1 : 0);
        end else begin
            if (charge && m_energy < EM) m_energy++;
            if (m_phase == 1) begin
                if ((a & m_act) != '0 || (f && m_left == 1)) begin
                    m_act = '0; m_phase = 2; m_left = CF;
                end else if (f) begin
                    m_left--;
                end
            end else if (m_phase == 2 && f) begin
                if (m_left == 1) m_phase = 0;
                else m_left--;
            end
        end
        m_pend = latched & ~m_grant;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_until_grant(input logic [2:0] want, input string tag);
        int n = 0;
        tick(1'b0, 3'b000, 3'b000);
        tick(1'b1, 3'b000, 3'b000);
        while (m_grant == '0 && n < 200) begin
            if (m_energy < CO) chk({tag, "_starved_avail"}, 32'(available), 32'd0);
            tick(1'b0, 3'b000, 3'b000);
            tick(1'b1, 3'b000, 3'b000);
            n++;
        end
        chk(tag, 32'(grant), 32'(want));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_phase != 0 && n < 50) begin
            tick(1'b0, 3'b000, 3'b000);
            tick(1'b1, 3'b000, 3'b000);
            n++;
        end
        chk(tag, 32'(state_o), 32'd0);
    endtask

    initial begin
        logic       f;
        logic [2:0] r;
        logic [2:0] a;

        // Power-on reset
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_energy", 32'(energy), 32'd15);
        @(negedge clk);
        rst = 1'b1;

        // Basic cycle
        tick(1'b0, 3'b001, 3'b000);
        chk("t1_pending", 32'(pending), 32'd1);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_energy", 32'(energy), 32'd10);
        tick(1'b0, 3'b000, 3'b000);
        chk("t1_grant_pulse", 32'(grant), 32'd0);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_act_f1", 32'(active), 32'd1);
        tick(1'b0, 3'b000, 3'b000);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_act_f2", 32'(active), 32'd1);
        tick(1'b0, 3'b000, 3'b000);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_act_f3", 32'(active), 32'd0);
        chk("t1_cool", 32'(state_o), 32'd2);
        tick(1'b0, 3'b000, 3'b000);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_cool_f1", 32'(state_o), 32'd2);
        tick(1'b0, 3'b000, 3'b000);
        tick(1'b1, 3'b000, 3'b000);
        chk("t1_idle", 32'(state_o), 32'd0);

        // Round-robin from rr=0, then energy starvation before index 0 is served
        tick(1'b0, 3'b001, 3'b000);
        run_until_grant(3'b001, "t2_setup");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 3'b000, 3'b000);
            tick(1'b1, 3'b000, 3'b000);
        end
        chk("t2_in_cool", 32'(state_o), 32'd2);
        tick(1'b0, 3'b101, 3'b000);
        chk("t2_pending", 32'(pending), 32'd5);
        run_until_grant(3'b100, "t2_first");
        chk("t2_pending_mid", 32'(pending), 32'd1);
        run_until_grant(3'b001, "t2_second");

        // Same-index request and abort handling on requester 1
        wait_idle("t3_idle");
        tick(1'b0, 3'b010, 3'b000);
        run_until_grant(3'b010, "t3_grant");
        tick(1'b0, 3'b011, 3'b000);
        chk("t6_pending", 32'(pending), 32'd1);
        tick(1'b0, 3'b000, 3'b001);
        chk("t3_other_abort", 32'(active), 32'd2);
        tick(1'b0, 3'b000, 3'b010);
        chk("t3_abort_active", 32'(active), 32'd0);
        chk("t3_abort_state", 32'(state_o), 32'd2);

        // Asynchronous reset in the middle of an activation
        wait_idle("t5_idle");
        run_until_grant(3'b001, "t5_pre");
        tick(1'b0, 3'b100, 3'b000);
        frame = 1'b0; req = '0; abort = '0;
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("t5_rst_energy", 32'(energy), 32'd15);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 3'b101, 3'b000);
        run_until_grant(3'b001, "t5_first");

        // Back-to-back grants drain the pool until a request has to wait
        wait_idle("t4_idle_a");
        tick(1'b0, 3'b010, 3'b000);
        run_until_grant(3'b010, "t4_second");
        wait_idle("t4_idle_b");
        tick(1'b0, 3'b100, 3'b000);
        run_until_grant(3'b100, "t4_third");
        wait_idle("t4_idle_c");
        tick(1'b0, 3'b001, 3'b000);
        run_until_grant(3'b001, "t4_starved");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            f = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            a = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick(f, r, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
